// File: rtl/tlul_arb_pkg.sv
// Shared types for the two-host TL-UL RAM arbiter.
// Holds the host index type, the fixed host numbering and the simplified
// single-beat TL-UL channel structs used on every port of the slice.
package tlul_arb_pkg;

   typedef logic [0:0] host_idx_t;

   localparam host_idx_t HostData  = 1'b0;
   localparam host_idx_t HostInstr = 1'b1;

   // Host-to-device: A-channel request plus D-channel ready.
   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   // Device-to-host: D-channel response plus A-channel ready.
   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_order_fifo.sv
// Order FIFO of host indices for requests in flight to the RAM.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   push_i        enqueue wdata_i (ignored when full)
//   pop_i         dequeue head (ignored when empty)
//   wdata_i       host index to enqueue
//   rdata_o       host index at the head
//   full_o        count == Depth
//   empty_o       count == 0
//   count_o       number of stored entries
// Pointers wrap modulo Depth, so Depth need not be a power of two.
module tlul_arb_order_fifo
   import tlul_arb_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  host_idx_t       wdata_i,
   output host_idx_t       rdata_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   host_idx_t [Depth-1:0] mem_q, mem_d;
   logic [PtrW-1:0]       wptr_q, wptr_d;
   logic [PtrW-1:0]       rptr_q, rptr_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rptr_q];
   assign count_o = cnt_q;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      do_push = push_i & ~full_o;
      do_pop  = pop_i & ~empty_o;
      if (do_push) begin
         mem_d[wptr_q] = wdata_i;
         wptr_d        = ptr_inc(wptr_q);
      end
      if (do_pop) begin
         rptr_d = ptr_inc(rptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/tlul_ram_arbiter.sv
// Two-host TL-UL arbiter in front of a shared single-port RAM.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   tl_h_i/tl_h_o  host ports; [0] = data side, [1] = instruction side
//   tl_d_o/tl_d_i  device port to the RAM
//   outstanding_o  requests accepted but not yet answered
//   err_o          sticky: a response arrived with nothing in flight
// Responses are routed by an order FIFO of host indices, relying on the RAM
// answering in request order; a_source is passed through untouched.
module tlul_ram_arbiter
   import tlul_arb_pkg::*;
#(
   parameter int unsigned Depth     = 2,
   parameter bit          FixedPrio = 1'b0,
   parameter int unsigned CntW      = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  tl_h2d_t [1:0]       tl_h_i,
   output tl_d2h_t [1:0]       tl_h_o,
   output tl_h2d_t             tl_d_o,
   input  tl_d2h_t             tl_d_i,
   output logic [CntW-1:0]     outstanding_o,
   output logic                err_o
);

   host_idx_t gnt_q, gnt_d;
   logic      lock_q, lock_d;
   host_idx_t rr_q, rr_d;
   logic      err_q, err_d;

   logic      [1:0] valid;
   host_idx_t winner;
   tl_h2d_t   req;
   logic      a_valid_out, d_ready_out, accept, pop, set_err;
   logic      full, empty;
   host_idx_t head;

   tlul_arb_order_fifo #(
      .Depth (Depth),
      .CntW  (CntW)
   ) u_order_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept),
      .pop_i   (pop),
      .wdata_i (winner),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (outstanding_o)
   );

   always_comb begin
      valid = {tl_h_i[1].a_valid, tl_h_i[0].a_valid};

      // With no candidate the winner falls back to host 0 so the device
      // port mirrors host 0's fields.
      winner = HostData;
      if (lock_q) begin
         winner = gnt_q;
      end else if (FixedPrio) begin
         winner = (valid[0] || !valid[1]) ? HostData : HostInstr;
      end else if (valid[rr_q]) begin
         winner = rr_q;
      end else if (valid[~rr_q]) begin
         winner = ~rr_q;
      end

      req         = tl_h_i[winner];
      a_valid_out = req.a_valid & ~full & ~rst_i;
      accept      = a_valid_out & tl_d_i.a_ready;

      tl_h_o[0]         = tl_d_i;
      tl_h_o[1]         = tl_d_i;
      tl_h_o[0].a_ready = 1'b0;
      tl_h_o[1].a_ready = 1'b0;
      tl_h_o[0].d_valid = 1'b0;
      tl_h_o[1].d_valid = 1'b0;
      tl_h_o[winner].a_ready = tl_d_i.a_ready & ~full & ~rst_i;

      // Empty FIFO: swallow any stray response and flag it.
      pop     = 1'b0;
      set_err = 1'b0;
      if (!empty) begin
         tl_h_o[head].d_valid = tl_d_i.d_valid & ~rst_i;
         d_ready_out          = tl_h_i[head].d_ready & ~rst_i;
         pop                  = tl_d_i.d_valid & d_ready_out;
      end else begin
         d_ready_out = ~rst_i;
         set_err     = tl_d_i.d_valid;
      end

      tl_d_o         = req;
      tl_d_o.a_valid = a_valid_out;
      tl_d_o.d_ready = d_ready_out;

      gnt_d  = winner;
      lock_d = lock_q;
      if (accept) begin
         lock_d = 1'b0;
      end else if (req.a_valid && !tl_d_i.a_ready) begin
         lock_d = 1'b1;
      end

      rr_d = rr_q;
      if (accept && !FixedPrio) begin
         rr_d = ~winner;
      end

      err_d = err_q | set_err;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_q  <= HostData;
         lock_q <= 1'b0;
         rr_q   <= HostData;
         err_q  <= 1'b0;
      end else begin
         gnt_q  <= gnt_d;
         lock_q <= lock_d;
         rr_q   <= rr_d;
         err_q  <= err_d;
      end
   end

   assign err_o = err_q;

endmodule
